// File: rtl/ucie_rdi_tx_arb_if.sv
// Requester-side and RDI-side transmit bundle for ucie_rdi_tx_arb, including the stall handshake.
// The master modport is the arbiter's view. The slave modport is the view of the adapter queues and RDI.
interface ucie_rdi_tx_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 512,
  parameter int USER_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ*USER_WIDTH-1:0] req_user;
  logic [NUM_REQ-1:0]            req_sop;
  logic [NUM_REQ-1:0]            req_eop;
  logic [NUM_REQ*6-1:0]          req_empty;
  logic [NUM_REQ-1:0]            req_ready;

  logic                          tx_valid;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic [USER_WIDTH-1:0]         tx_user;
  logic                          tx_sop;
  logic                          tx_eop;
  logic [5:0]                    tx_empty;
  logic                          tx_ready;

  logic                          pl_stallreq;
  logic                          lp_stallack;

  modport master (
    input  req_valid, req_data, req_user, req_sop, req_eop, req_empty, tx_ready, pl_stallreq,
    output req_ready, tx_valid, tx_data, tx_user, tx_sop, tx_eop, tx_empty, lp_stallack
  );

  modport slave (
    output req_valid, req_data, req_user, req_sop, req_eop, req_empty, tx_ready, pl_stallreq,
    input  req_ready, tx_valid, tx_data, tx_user, tx_sop, tx_eop, tx_empty, lp_stallack
  );
endinterface

// File: rtl/ucie_rdi_tx_arb.sv
// Packet round-robin arbiter onto RDI TX with a stall handshake; optional grant watchdog via UCIE_RDI_ARB_WATCHDOG_EN.
// Latency: 0-cycle data mux, 1-cycle arbitration bubble. Backpressure: tx_ready passes combinationally to the granted req_ready.
module ucie_rdi_tx_arb #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 512,
  parameter int USER_WIDTH  = 16,
  parameter int WDOG_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  ucie_rdi_tx_arb_if.master          bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       sop_err,
  output logic                       wdog_timeout
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, GRANT, STALL} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] rr_idx, cand;
  logic          rr_found;
  logic          first_q, first_d;
  logic          stallack_q;
  logic          tx_valid_w;
  logic          xfer;
  logic          wdog_fire;

  // Round-robin search starting just after the last completed grant.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_q) + k) % NUM_REQ);
      if (!rr_found && bus.req_valid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  assign tx_valid_w   = (state_q == GRANT) && bus.req_valid[grant_q];
  assign xfer         = tx_valid_w && bus.tx_ready;
  assign bus.tx_valid = tx_valid_w;
  assign bus.tx_data  = bus.req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  assign bus.tx_user  = bus.req_user[int'(grant_q)*USER_WIDTH +: USER_WIDTH];
  assign bus.tx_empty = bus.req_empty[int'(grant_q)*6 +: 6];
  assign bus.tx_sop   = bus.req_sop[grant_q];
  assign bus.tx_eop   = bus.req_eop[grant_q];

  always_comb begin
    bus.req_ready = '0;
    if (state_q == GRANT) bus.req_ready[grant_q] = bus.tx_ready;
  end

  // The first beat of a grant without sop is still forwarded; it is only flagged.
  assign sop_err         = xfer && first_q && !bus.tx_sop;
  assign grant_idx       = grant_q;
  assign bus.lp_stallack = stallack_q;
  assign wdog_timeout    = wdog_fire;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    first_d = first_q;
    case (state_q)
      IDLE: begin
        if (bus.pl_stallreq) begin
          state_d = STALL;
        end else if (rr_found) begin
          state_d = GRANT;
          grant_d = rr_idx;
          first_d = 1'b1;
        end
      end
      GRANT: begin
        if (xfer) first_d = 1'b0;
        if (xfer && bus.tx_eop) begin
          last_d  = grant_q;
          state_d = bus.pl_stallreq ? STALL : IDLE;
        end else if (wdog_fire) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      STALL: begin
        if (!bus.pl_stallreq) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= IW'(NUM_REQ - 1);
      first_q    <= 1'b0;
      stallack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      first_q    <= first_d;
      stallack_q <= (state_d == STALL);
    end
  end

`ifdef UCIE_RDI_ARB_WATCHDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  logic [CW-1:0] wdog_cnt_q;

  // Counts GRANT cycles with no valid beat; fires on the WDOG_CYCLES-th such cycle.
  assign wdog_fire = (state_q == GRANT) && !tx_valid_w && (wdog_cnt_q == CW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || (state_q != GRANT) || xfer || wdog_fire) begin
      wdog_cnt_q <= '0;
    end else if (!tx_valid_w) begin
      wdog_cnt_q <= wdog_cnt_q + 1'b1;
    end
  end
`else
  localparam int wdog_cycles_unused = WDOG_CYCLES;
  assign wdog_fire = 1'b0;
`endif

endmodule
